// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for alu_exec.
// Optional multiply support is enabled by defining ALU_MUL_EN.
package alu_pkg;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpNot  = 4'd5;
  localparam logic [3:0] OpShl  = 4'd6;
  localparam logic [3:0] OpShr  = 4'd7;
  localparam logic [3:0] OpPass = 4'd9;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OpMul  = 4'd8;
`endif

  typedef logic [1:0] alu_state_t;

  localparam alu_state_t StIdle = 2'd0;
`ifdef ALU_MUL_EN
  localparam alu_state_t StMul  = 2'd1;
  localparam alu_state_t StWb   = 2'd2;
`endif

endpackage

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, W+1 steps.
// done_o is high in the cycle whose step is the last one; product_o is the
// accumulator value after the current step, so it is final while done_o is high.
module mul_seq #(
  parameter int unsigned W = 7
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [W:0]     a_i,
  input  logic [W:0]     b_i,
  output logic           done_o,
  output logic [2*W+1:0] product_o
);

  localparam int unsigned CntW = $clog2(W + 2);

  logic [2*W+1:0] acc_q, acc_d;
  logic [2*W+1:0] mcand_q, mcand_d;
  logic [W:0]     mplier_q, mplier_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           last;

  assign last      = busy_q && (cnt_q == CntW'(W));
  assign done_o    = last;
  assign product_o = acc_d;

  // Load operands on start, otherwise do one shift-add step while busy
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = {{(W + 1){1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (last) busy_d = 1'b0;
    end
  end

  // Multiplier state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage with registered write-back and zero/carry flags.
// Single-cycle ops complete one cycle after acceptance. When ALU_MUL_EN is
// defined, opcode 8 runs a multi-cycle multiply through mul_seq; otherwise it
// is a NOP and op_ready is tied high.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned W = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [3:0] op,
  input  logic [3:0] rd_in,
  input  logic [W:0] s,
  input  logic [W:0] t,
  output logic [W:0] data,
  output logic [3:0] rd,
  output logic       reg_ena,
  output logic       zf,
  output logic       cf
);

  logic       accept;
  logic [W:0] alu_res;
  logic       alu_cf;
  logic       alu_wr;

  logic       wb_en;
  logic [W:0] wb_res;
  logic       wb_cf;
  logic [3:0] wb_rd;

  logic [W:0] data_q, data_d;
  logic [3:0] rd_q, rd_d;
  logic       reg_ena_q, reg_ena_d;
  logic       zf_q, zf_d;
  logic       cf_q, cf_d;

  assign accept = op_valid & op_ready;

  // Single-cycle datapath; alu_wr is low for opcodes that write nothing
  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_wr  = 1'b1;
    case (op)
      OpAdd:   {alu_cf, alu_res} = {1'b0, s} + {1'b0, t};
      OpSub:   {alu_cf, alu_res} = {1'b0, s} - {1'b0, t};
      OpAnd:   alu_res = s & t;
      OpOr:    alu_res = s | t;
      OpXor:   alu_res = s ^ t;
      OpNot:   alu_res = ~s;
      OpShl:   {alu_cf, alu_res} = {s, 1'b0};
      OpShr: begin
        alu_res = s >> 1;
        alu_cf  = s[0];
      end
      OpPass:  alu_res = t;
      default: alu_wr = 1'b0;
    endcase
  end

`ifdef ALU_MUL_EN
  alu_state_t     state_q, state_d;
  logic           mul_start;
  logic           mul_done;
  logic [2*W+1:0] mul_prod;
  logic [3:0]     mul_rd_q, mul_rd_d;

  mul_seq #(
    .W(W)
  ) u_mul_seq (
    .clk_i    (clk),
    .rst_i    (reset),
    .start_i  (mul_start),
    .a_i      (s),
    .b_i      (t),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );

  assign op_ready = (state_q == StIdle);

  // FSM: select write-back source; MUL result is registered on its last step
  // so reg_ena lands in the WB cycle
  always_comb begin
    state_d   = state_q;
    mul_rd_d  = mul_rd_q;
    mul_start = 1'b0;
    wb_en     = 1'b0;
    wb_res    = alu_res;
    wb_cf     = alu_cf;
    wb_rd     = rd_in;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (op == OpMul) begin
            mul_start = 1'b1;
            mul_rd_d  = rd_in;
            state_d   = StMul;
          end else begin
            wb_en = alu_wr;
          end
        end
      end
      StMul: begin
        if (mul_done) begin
          wb_en   = 1'b1;
          wb_res  = mul_prod[W:0];
          wb_cf   = |mul_prod[2*W+1:W+1];
          wb_rd   = mul_rd_q;
          state_d = StWb;
        end
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state and latched MUL destination
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      mul_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      mul_rd_q <= mul_rd_d;
    end
  end
`else
  assign op_ready = 1'b1;

  // Every accepted op resolves in one cycle
  always_comb begin
    wb_en  = accept & alu_wr;
    wb_res = alu_res;
    wb_cf  = alu_cf;
    wb_rd  = rd_in;
  end
`endif

  // Write-back: results and flags move only on a write; rd 0 suppresses the strobe
  always_comb begin
    data_d    = data_q;
    rd_d      = rd_q;
    zf_d      = zf_q;
    cf_d      = cf_q;
    reg_ena_d = 1'b0;
    if (wb_en) begin
      data_d    = wb_res;
      rd_d      = wb_rd;
      zf_d      = (wb_res == '0);
      cf_d      = wb_cf;
      reg_ena_d = (wb_rd != 4'd0);
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      rd_q      <= '0;
      reg_ena_q <= 1'b0;
      zf_q      <= 1'b0;
      cf_q      <= 1'b0;
    end else begin
      data_q    <= data_d;
      rd_q      <= rd_d;
      reg_ena_q <= reg_ena_d;
      zf_q      <= zf_d;
      cf_q      <= cf_d;
    end
  end

  assign data    = data_q;
  assign rd      = rd_q;
  assign reg_ena = reg_ena_q;
  assign zf      = zf_q;
  assign cf      = cf_q;

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter W, default 7, meaning operand/result bit width minus 1.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port op_valid  input  1  upstream presents an operation this cycle.
REQ-005 SHALL have port op_ready  output  1  block accepts an operation this cycle.
REQ-006 SHALL have port op  input  4  opcode.
REQ-007 SHALL have port rd_in  input  4  destination register index of the operation.
REQ-008 SHALL have ports s, t  input  W+1 each  source operands from register-file read ports.
REQ-009 SHALL have port data  output  W+1  registered write-back result.
REQ-010 SHALL have port rd  output  4  registered write-back index.
REQ-011 SHALL have port reg_ena  output  1  one-cycle write-back strobe.
REQ-012 SHALL have ports zf, cf  output  1 each  zero and carry/borrow flags.

Function
REQ-013 SHALL accept an operation on a rising edge where op_valid and op_ready are both 1; otherwise inputs are ignored.
REQ-014 SHALL decode opcodes: 0 ADD s+t, 1 SUB s-t, 2 AND, 3 OR, 4 XOR, 5 NOT s, 6 SHL s by 1 (zero fill), 7 SHR s by 1 (zero fill), 8 MUL low W+1 bits of s*t, 9 PASS t; 10-15 NOP.
REQ-015 SHALL, for opcodes 0-7 and 9, present data/rd and pulse reg_ena exactly one cycle after acceptance (latency 1), with op_ready remaining 1, allowing back-to-back acceptance.
REQ-016 SHALL set cf to the carry-out of ADD, the borrow (s<t, unsigned) of SUB, the shifted-out bit of SHL/SHR, and 0 for all other writing ops.
REQ-017 SHALL set zf to 1 exactly when the written result is all zeros.
REQ-018 SHALL update data, zf, cf only on write-back cycles; they hold otherwise.
REQ-019 SHALL not assert reg_ena when rd_in is 0, but SHALL still update data, zf, cf for that operation.
REQ-020 SHALL treat NOP as accepted with no reg_ena, no flag or data change.
REQ-021 SHALL implement an FSM with states IDLE, MUL, WB: IDLE accepts ops; opcode 8 moves IDLE->MUL; MUL iterates one shift-add step per cycle for W+1 cycles then moves to WB; WB pulses reg_ena one cycle and returns to IDLE.
REQ-022 SHALL drive op_ready 0 from the cycle after MUL acceptance until the WB cycle inclusive, so MUL latency is W+2 cycles from acceptance to reg_ena.
REQ-023 SHALL latch s, t, rd_in at MUL acceptance; input changes during MUL SHALL not affect the result.
REQ-024 SHALL set cf to 1 after MUL when any bit of the 2W+2-bit product above bit W is 1.

Reset
REQ-025 SHALL, on reset assertion, immediately clear data, rd, reg_ena, zf, cf to 0, enter IDLE, and drive op_ready 1.
REQ-026 SHALL abort a MUL in progress on reset with no write-back.

Configuration
REQ-027 SHALL include the MUL opcode, MUL state and multiplier only when macro ALU_MUL_EN is defined.
REQ-028 SHALL, without ALU_MUL_EN, decode opcode 8 as NOP and hold op_ready constant 1.

Structure
REQ-029 SHALL take opcode constants and the FSM state type from shared package alu_pkg.
REQ-030 SHALL place the iterative shift-add multiplier in sub-module mul_seq (start, done, operands, product).

Verification (W=7)
REQ-031 ADD s=0xF0, t=0x20, rd_in=3 -> next cycle data=0x10, rd=3, reg_ena=1, cf=1, zf=0.
REQ-032 SUB s=0x05, t=0x05, rd_in=0 -> data=0x00, zf=1, cf=0, reg_ena stays 0.
REQ-033 MUL s=0x0C, t=0x0B, rd_in=2 -> op_ready 0 for 9 cycles, reg_ena 9 cycles after acceptance, data=0x84, cf=0; s=0x20, t=0x10 -> data=0x00, cf=1, zf=1.
REQ-034 Back-to-back ADD, XOR, SHL on consecutive cycles -> three consecutive reg_ena pulses with correct data each cycle.
REQ-035 Reset asserted 4 cycles into MUL -> outputs 0 at once, no reg_ena, next op accepted normally after release.
REQ-036 Build without ALU_MUL_EN, issue opcode 8 -> no reg_ena, op_ready stays 1, flags unchanged.
